// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared defaults and FSM encoding for the 1-to-N stream demux.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_N_OUT  = 4;
    localparam int DEF_SEL_W  = 2;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

endpackage
`default_nettype wire

// File: rtl/stream_demux_chan_reg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_chan_reg
// Description : One-entry valid/ready output register for a demux channel.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_chan_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    // A load wins over a drain, so a simultaneous drain+load keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/stream_demux_1x4.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1x4
// Description : Packet-aware registered 1-to-N valid/ready stream demux.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1x4
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_OUT  = DEF_N_OUT,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_last,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_last,
    output logic                    busy,
    output logic [SEL_W-1:0]        cur_sel,
    output logic [7:0]              drop_cnt
);

    localparam int             c_PAD      = 1 << SEL_W;
    localparam logic [SEL_W:0] c_NOUT_EXT = (SEL_W + 1)'(N_OUT);

    logic [0:0]       r_state;
    logic [SEL_W-1:0] r_cur_sel;
    logic [7:0]       r_drop;

    logic [SEL_W-1:0] w_target;
    logic             w_illegal;
    logic             w_accept;
    logic [c_PAD-1:0] w_vld_pad;
    logic [c_PAD-1:0] w_rdy_pad;
    logic [N_OUT-1:0] w_load;

    // Channel flags are padded to the full select range so any select value indexes safely.
    always_comb begin
        w_vld_pad              = '0;
        w_rdy_pad              = '0;
        w_vld_pad[N_OUT-1:0]   = out_valid;
        w_rdy_pad[N_OUT-1:0]   = out_ready;
        w_target               = (r_state == S_LOCK) ? r_cur_sel : in_sel;
        w_illegal              = (r_state == S_IDLE) && ({1'b0, in_sel} >= c_NOUT_EXT);
        in_ready               = w_illegal | ~w_vld_pad[w_target] | w_rdy_pad[w_target];
    end

    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cur_sel <= '0;
        end else if (w_accept) begin
            if (r_state == S_IDLE) begin
                if (!w_illegal && !in_last) begin
                    r_state   <= S_LOCK;
                    r_cur_sel <= in_sel;
                end
            end else if (in_last) begin
                r_state   <= S_IDLE;
                r_cur_sel <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (w_accept && w_illegal && (r_drop != DROP_MAX)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_chan
        assign w_load[k] = w_accept & ~w_illegal & (w_target == SEL_W'(k));

        stream_demux_chan_reg #(
            .DATA_W (DATA_W)
        ) u_chan_reg (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[k]),
            .i_data  (in_data),
            .i_last  (in_last),
            .i_ready (out_ready[k]),
            .o_valid (out_valid[k]),
            .o_data  (out_data[k*DATA_W +: DATA_W]),
            .o_last  (out_last[k])
        );
    end

    assign busy     = (r_state == S_LOCK);
    assign cur_sel  = r_cur_sel;
    assign drop_cnt = r_drop;

endmodule
`default_nettype wire
